pipeline_stage_arbiter: RTL and testbench
=========================================

Name: pipeline_stage_arbiter

Overview:
- Round-robin arbiter that shares one downstream pipeline stage among NUM_REQ upstream providers.
- Each provider presents a valid/ready data channel plus sideband control bits. The block selects one provider per cycle and registers the accepted beat into a single-entry output holding register, which drives the downstream data channel.
- Sits in front of a pipeline_stage_interconnect input, for example where several sources share one execution or memory stage.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- DATA_WIDTH, 32, data bits per beat.
- CTRL_WIDTH, 16, control sideband bits per beat.
- IDX_WIDTH, $clog2(NUM_REQ) (minimum 1), width of the requester index.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_mask_i  in  NUM_REQ  bit i = 1 enables requester i; a masked requester is never granted.
- axis_s_data_tvalid  in  NUM_REQ  per-requester valid.
- axis_s_data_tready  out  NUM_REQ  per-requester ready, at most one bit high.
- axis_s_data_tdata  in  NUM_REQ*DATA_WIDTH  requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- ctrl_data_i  in  NUM_REQ*CTRL_WIDTH  requester i occupies slice [i*CTRL_WIDTH +: CTRL_WIDTH].
- axis_m_data_tvalid  out  1  holding register full.
- axis_m_data_tready  in  1  downstream ready.
- axis_m_data_tdata  out  DATA_WIDTH  held data.
- ctrl_data_o  out  CTRL_WIDTH  held control bits.
- grant_id_o  out  IDX_WIDTH  index of the requester whose beat is currently held.

Behaviour:
- Reset state (rst high at a clock edge):
  - full = 0, so axis_m_data_tvalid = 0.
  - axis_m_data_tdata = 0, ctrl_data_o = 0, grant_id_o = 0.
  - Round-robin pointer ptr = NUM_REQ-1, so the first search starts at requester 0.
- Reset behaviour:
  - While rst is high, axis_s_data_tready = 0.
  - Reset asserted mid-transfer drops any held beat; that beat is not delivered.
- Eligible set: elig[i] = axis_s_data_tvalid[i] & req_mask_i[i].
- Selection (combinational): sel = the first eligible index found scanning ptr+1, ptr+2, ..., wrapping modulo NUM_REQ, ending at ptr.
  - If no requester is eligible, there is no selection.
- Accept condition: can_accept = !full | axis_m_data_tready.
- Ready outputs:
  - axis_s_data_tready[sel] = can_accept & any(elig).
  - All other ready bits are 0.
  - Ready may depend on valid. Valid never depends on ready.
- Upstream transfer: occurs when tvalid & tready are both high for the same requester.
  - On that edge: held data <= that requester's tdata slice; ctrl <= its ctrl slice; grant_id_o <= sel; ptr <= sel; full <= 1.
- Downstream transfer: axis_m_data_tvalid & axis_m_data_tready.
  - If no upstream transfer occurs on the same edge, full <= 0.
- Simultaneous downstream pop and upstream push: the register is overwritten with the new beat and full stays 1. This gives a throughput of 1 beat/cycle.
- Latency: a beat accepted at edge N appears on axis_m_data_* after edge N (one cycle).
- Stall: while full and axis_m_data_tready = 0, all upstream readies are 0; held data, ctrl and grant_id_o are stable.
- Fairness: with k requesters continuously valid and unmasked, each is granted exactly once in every k consecutive transfers.
- A requester that deasserts valid without being granted loses no state; ptr changes only on a transfer.
- Mask changes take effect in the same cycle. Masking a requester never affects a beat already held.
- An all-zero mask or no valid requesters: no grant, and the holding register drains normally.

Test Plan:
- Reset, then idle: all tready = 0 while rst is high. After reset, axis_m_data_tvalid = 0, grant_id_o = 0 and data = 0; with no valid inputs, no tready is high.
- Single requester, NUM_REQ=2: req1 valid with data 0x11, ctrl 0x5, m_tready = 1 -> tready = 2'b10. The next cycle m_tvalid = 1, data = 0x11, ctrl = 0x5, grant_id = 1.
- Round-robin: req0 and req1 both continuously valid (data 0xA0 and 0xB0), m_tready = 1 -> output sequence 0xA0, 0xB0, 0xA0, 0xB0 with grant_id 0, 1, 0, 1 and m_tvalid high every cycle.
- Downstream stall: load 0xA0, then hold m_tready = 0 for 3 cycles with both requesters valid -> all tready = 0 and the output stays 0xA0/grant_id 0. On release, 0xA0 is consumed and 0xB0 from req1 is accepted on the same edge.
- Mask: req_mask_i = 2'b01 with both valid -> only req0 is granted, 3 consecutive 0xA0 beats. Set the mask to 2'b11 -> the next grant is req1.
- Reset mid-operation: with full = 1 (data 0xB0), assert rst for one cycle -> m_tvalid = 0 and data = 0. After reset the first grant goes to req0 even though req1 was granted last.

Source files
------------

// File: rtl/pipeline_stage_arbiter.sv
// Round-robin arbiter sharing one downstream valid/ready stage among NUM_REQ
// upstream providers, with a single-entry output holding register.
module pipeline_stage_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CTRL_WIDTH = 16,
   parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_mask_i,
   input  logic [NUM_REQ-1:0]              axis_s_data_tvalid,
   output logic [NUM_REQ-1:0]              axis_s_data_tready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   axis_s_data_tdata,
   input  logic [NUM_REQ*CTRL_WIDTH-1:0]   ctrl_data_i,
   output logic                            axis_m_data_tvalid,
   input  logic                            axis_m_data_tready,
   output logic [DATA_WIDTH-1:0]           axis_m_data_tdata,
   output logic [CTRL_WIDTH-1:0]           ctrl_data_o,
   output logic [IDX_WIDTH-1:0]            grant_id_o
);

   logic [NUM_REQ-1:0]    elig;
   logic [IDX_WIDTH-1:0]  ptr;
   logic [IDX_WIDTH-1:0]  sel;
   logic [IDX_WIDTH-1:0]  cand;
   logic                  sel_valid;
   logic                  can_accept;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [CTRL_WIDTH-1:0] sel_ctrl;

   assign elig       = axis_s_data_tvalid & req_mask_i;
   assign can_accept = !axis_m_data_tvalid || axis_m_data_tready;
   assign push       = sel_valid && can_accept;
   assign pop        = axis_m_data_tvalid && axis_m_data_tready;

   // Search starts just after the last granted index and wraps back to it.
   always_comb begin
      sel_valid          = 1'b0;
      sel                = '0;
      cand               = '0;
      axis_s_data_tready = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_WIDTH'((32'(ptr) + off) % NUM_REQ);
         if (!sel_valid && elig[cand]) begin
            sel_valid = 1'b1;
            sel       = cand;
         end
      end
      sel_data = axis_s_data_tdata[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
      sel_ctrl = ctrl_data_i[32'(sel)*CTRL_WIDTH +: CTRL_WIDTH];
      if (sel_valid && can_accept && !rst) begin
         axis_s_data_tready[sel] = 1'b1;
      end
   end

   // Holding register: a push overwrites (even on a same-cycle pop), a lone pop empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         axis_m_data_tvalid <= 1'b0;
         axis_m_data_tdata  <= '0;
         ctrl_data_o        <= '0;
         grant_id_o         <= '0;
         ptr                <= IDX_WIDTH'(NUM_REQ - 1);
      end else if (push) begin
         axis_m_data_tvalid <= 1'b1;
         axis_m_data_tdata  <= sel_data;
         ctrl_data_o        <= sel_ctrl;
         grant_id_o         <= sel;
         ptr                <= sel;
      end else if (pop) begin
         axis_m_data_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_stage_arbiter.sv
// Table-driven bench for pipeline_stage_arbiter (NUM_REQ=2) with a beat scoreboard.
module tb_pipeline_stage_arbiter;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned DW      = 32;
   localparam int unsigned CW      = 16;
   localparam int unsigned IW      = 1;
   localparam logic [CW-1:0] CTRL0 = 16'h0003;
   localparam logic [CW-1:0] CTRL1 = 16'h0005;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_REQ-1:0]      req_mask_i;
   logic [NUM_REQ-1:0]      s_tvalid;
   logic [NUM_REQ-1:0]      s_tready;
   logic [NUM_REQ*DW-1:0]   s_tdata;
   logic [NUM_REQ*CW-1:0]   ctrl_in;
   logic                    m_tvalid;
   logic                    m_tready;
   logic [DW-1:0]           m_tdata;
   logic [CW-1:0]           ctrl_out;
   logic [IW-1:0]           grant_id;

   pipeline_stage_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .IDX_WIDTH(IW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_mask_i         (req_mask_i),
      .axis_s_data_tvalid (s_tvalid),
      .axis_s_data_tready (s_tready),
      .axis_s_data_tdata  (s_tdata),
      .ctrl_data_i        (ctrl_in),
      .axis_m_data_tvalid (m_tvalid),
      .axis_m_data_tready (m_tready),
      .axis_m_data_tdata  (m_tdata),
      .ctrl_data_o        (ctrl_out),
      .grant_id_o         (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic [1:0]    mask;
      logic [1:0]    valid;
      logic          mrdy;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    exp_tready;
      logic          exp_mv;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
      logic [IW-1:0] gid;
   } beat_t;

   vec_t  vecs[21];
   beat_t sb[$];
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_row(input int i);
      vec_t  v;
      beat_t b;
      v = vecs[i];
      @(posedge clk);
      #1;
      rst        = v.rst;
      req_mask_i = v.mask;
      s_tvalid   = v.valid;
      m_tready   = v.mrdy;
      s_tdata    = {v.d1, v.d0};
      @(negedge clk);
      check($sformatf("row%0d_tready", i), 32'(s_tready), 32'(v.exp_tready));
      check($sformatf("row%0d_mvalid", i), 32'(m_tvalid), 32'(v.exp_mv));
      // Downstream transfer on the coming edge: compare against the oldest expected beat.
      if (m_tvalid && m_tready && !rst) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL row%0d_sb_underflow: got data %h with no beat expected", i, m_tdata);
         end else begin
            b = sb.pop_front();
            total--;
            check($sformatf("row%0d_data", i), m_tdata, b.data);
            check($sformatf("row%0d_ctrl", i), 32'(ctrl_out), 32'(b.ctrl));
            check($sformatf("row%0d_gid", i), 32'(grant_id), 32'(b.gid));
         end
      end
      if (v.rst) begin
         sb.delete();
      end else if (v.exp_tready != 2'b00) begin
         b.gid  = v.exp_tready[1] ? 1'b1 : 1'b0;
         b.data = v.exp_tready[1] ? v.d1 : v.d0;
         b.ctrl = v.exp_tready[1] ? CTRL1 : CTRL0;
         sb.push_back(b);
      end
   endtask

   initial begin
      //          rst mask   valid  mrdy d0      d1      tready mv
      vecs[0]  = '{0, 2'b11, 2'b10, 1, 32'h00, 32'h11, 2'b10, 0}; // single req1
      vecs[1]  = '{0, 2'b11, 2'b00, 1, 32'h00, 32'h11, 2'b00, 1};
      vecs[2]  = '{0, 2'b11, 2'b11, 1, 32'hA0, 32'hB0, 2'b01, 0}; // round robin
      vecs[3]  = '{0, 2'b11, 2'b11, 1, 32'hA0, 32'hB0, 2'b10, 1};
      vecs[4]  = '{0, 2'b11, 2'b11, 1, 32'hA0, 32'hB0, 2'b01, 1};
      vecs[5]  = '{0, 2'b11, 2'b11, 1, 32'hA0, 32'hB0, 2'b10, 1};
      vecs[6]  = '{0, 2'b11, 2'b00, 1, 32'hA0, 32'hB0, 2'b00, 1};
      vecs[7]  = '{0, 2'b11, 2'b01, 1, 32'hA0, 32'hB0, 2'b01, 0}; // load A0, then stall
      vecs[8]  = '{0, 2'b11, 2'b11, 0, 32'hA0, 32'hB0, 2'b00, 1};
      vecs[9]  = '{0, 2'b11, 2'b11, 0, 32'hA0, 32'hB0, 2'b00, 1};
      vecs[10] = '{0, 2'b11, 2'b11, 0, 32'hA0, 32'hB0, 2'b00, 1};
      vecs[11] = '{0, 2'b11, 2'b11, 1, 32'hA0, 32'hB0, 2'b10, 1}; // release: pop A0, push B0
      vecs[12] = '{0, 2'b01, 2'b11, 1, 32'hA0, 32'hB0, 2'b01, 1}; // mask to req0
      vecs[13] = '{0, 2'b01, 2'b11, 1, 32'hA0, 32'hB0, 2'b01, 1};
      vecs[14] = '{0, 2'b01, 2'b11, 1, 32'hA0, 32'hB0, 2'b01, 1};
      vecs[15] = '{0, 2'b11, 2'b11, 1, 32'hA0, 32'hB0, 2'b10, 1}; // unmask -> req1
      vecs[16] = '{1, 2'b11, 2'b11, 0, 32'hA0, 32'hB0, 2'b00, 1}; // reset with B0 held
      vecs[17] = '{0, 2'b11, 2'b11, 0, 32'hA0, 32'hB0, 2'b01, 0}; // first grant req0
      vecs[18] = '{0, 2'b11, 2'b00, 1, 32'hA0, 32'hB0, 2'b00, 1};
      vecs[19] = '{0, 2'b11, 2'b00, 1, 32'hA0, 32'hB0, 2'b00, 0};
      vecs[20] = '{0, 2'b00, 2'b11, 1, 32'hA0, 32'hB0, 2'b00, 0}; // all masked

      rst        = 1'b1;
      req_mask_i = 2'b11;
      s_tvalid   = 2'b11;
      m_tready   = 1'b1;
      s_tdata    = {32'hB0, 32'hA0};
      ctrl_in    = {CTRL1, CTRL0};

      // Reset with requesters valid: no ready while rst is high.
      @(posedge clk);
      @(negedge clk);
      check("rst_tready_a", 32'(s_tready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("rst_tready_b", 32'(s_tready), 32'h0);
      #1;
      rst      = 1'b0;
      s_tvalid = 2'b00;
      @(posedge clk);
      @(negedge clk);
      check("idle_mvalid", 32'(m_tvalid), 32'h0);
      check("idle_data", m_tdata, 32'h0);
      check("idle_ctrl", 32'(ctrl_out), 32'h0);
      check("idle_gid", 32'(grant_id), 32'h0);
      check("idle_tready", 32'(s_tready), 32'h0);

      for (int i = 0; i <= 16; i++) apply_row(i);

      // After the mid-operation reset edge the held beat must be gone.
      @(posedge clk);
      #1;
      check("post_rst_mvalid", 32'(m_tvalid), 32'h0);
      check("post_rst_data", m_tdata, 32'h0);
      check("post_rst_gid", 32'(grant_id), 32'h0);

      for (int i = 17; i <= 20; i++) apply_row(i);

      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
